// File: rtl/fp_addsub_sched_if.sv
// Scheduler bundle: two requester ports, the datapath control/operand/result
// wires, the tagged result port and status.
// slave = scheduler view, master = requesters, datapath and result consumer.
interface fp_addsub_sched_if #(
    parameter int MW = 48,
    parameter int EW = 16
);
    logic          req0_valid;
    logic          req0_ready;
    logic [MW-1:0] req0_mant;
    logic [EW-1:0] req0_exp;
    logic          req0_op;

    logic          req1_valid;
    logic          req1_ready;
    logic [MW-1:0] req1_mant;
    logic [EW-1:0] req1_exp;
    logic          req1_op;

    logic          pipe_clear;
    logic          pipe_load;
    logic [MW-1:0] pipe_mant;
    logic [EW-1:0] pipe_exp;
    logic          pipe_op;
    logic [22:0]   pipe_mant_f;
    logic [7:0]    pipe_exp_f;
    logic          pipe_sign_f;

    logic          res_valid;
    logic          res_ready;
    logic          res_tag;
    logic [22:0]   res_mant;
    logic [7:0]    res_exp;
    logic          res_sign;

    logic          busy;
    logic [2:0]    inflight;

    modport slave (
        input  req0_valid, req0_mant, req0_exp, req0_op,
        input  req1_valid, req1_mant, req1_exp, req1_op,
        input  pipe_mant_f, pipe_exp_f, pipe_sign_f,
        input  res_ready,
        output req0_ready, req1_ready,
        output pipe_clear, pipe_load, pipe_mant, pipe_exp, pipe_op,
        output res_valid, res_tag, res_mant, res_exp, res_sign,
        output busy, inflight
    );

    modport master (
        output req0_valid, req0_mant, req0_exp, req0_op,
        output req1_valid, req1_mant, req1_exp, req1_op,
        output pipe_mant_f, pipe_exp_f, pipe_sign_f,
        output res_ready,
        input  req0_ready, req1_ready,
        input  pipe_clear, pipe_load, pipe_mant, pipe_exp, pipe_op,
        input  res_valid, res_tag, res_mant, res_exp, res_sign,
        input  busy, inflight
    );
endinterface

// File: rtl/fp_addsub_sched.sv
// Issue scheduler for the pipelined FP add/sub datapath. Two requesters share
// the pipe round-robin; a valid/tag shadow of the stage registers tracks which
// slots are live and who owns them. Result back-pressure stalls the whole pipe.
module fp_addsub_sched #(
    parameter int LAT = 5,
    parameter int MW  = 48,
    parameter int EW  = 16
) (
    input  logic             clk,
    input  logic             clear,
    fp_addsub_sched_if.slave bus
);
    localparam int CW = 3;

    logic [LAT:1]  v_q;
    logic [LAT:1]  t_q;
    logic          last_q;
    logic [CW-1:0] inflight_q;

    logic          stall;
    logic          load;
    logic          grant0;
    logic          grant1;
    logic          rdy0;
    logic          rdy1;
    logic          accept;
    logic [LAT:1]  v_next;
    logic [CW-1:0] cnt_next;
    logic [MW-1:0] mant_sel;
    logic [EW-1:0] exp_sel;
    logic          op_sel;

    // Advance/stall, round-robin grant and operand mux; idle slots issue zero bubbles.
    always_comb begin
        stall    = v_q[LAT] & ~bus.res_ready;
        load     = ~clear & ~stall;
        grant0   = bus.req0_valid & (~bus.req1_valid | last_q);
        grant1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
        rdy0     = load & grant0;
        rdy1     = load & grant1;
        accept   = rdy0 | rdy1;
        mant_sel = '0;
        exp_sel  = '0;
        op_sel   = 1'b0;
        if (rdy0) begin
            mant_sel = bus.req0_mant;
            exp_sel  = bus.req0_exp;
            op_sel   = bus.req0_op;
        end else if (rdy1) begin
            mant_sel = bus.req1_mant;
            exp_sel  = bus.req1_exp;
            op_sel   = bus.req1_op;
        end
        v_next   = {v_q[LAT-1:1], accept};
        cnt_next = '0;
        for (int k = 1; k <= LAT; k++) begin
            cnt_next = cnt_next + {{(CW-1){1'b0}}, v_next[k]};
        end
    end

    // Slot shadow shifts only when the datapath loads; clear discards everything in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            v_q        <= '0;
            t_q        <= '0;
            last_q     <= 1'b1;
            inflight_q <= '0;
        end else if (load) begin
            v_q        <= v_next;
            t_q        <= {t_q[LAT-1:1], rdy1};
            inflight_q <= cnt_next;
            if (accept) begin
                last_q <= rdy1;
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.pipe_clear = clear;
    assign bus.pipe_load  = load;
    assign bus.pipe_mant  = mant_sel;
    assign bus.pipe_exp   = exp_sel;
    assign bus.pipe_op    = op_sel;
    assign bus.res_valid  = v_q[LAT] & ~clear;
    assign bus.res_tag    = t_q[LAT];
    assign bus.res_mant   = bus.pipe_mant_f;
    assign bus.res_exp    = bus.pipe_exp_f;
    assign bus.res_sign   = bus.pipe_sign_f;
    assign bus.busy       = |v_q;
    assign bus.inflight   = inflight_q;
endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched. A stand-in 5-stage datapath loads on
// pipe_load and produces mant_f = low mantissa >> 1, exp_f = high exponent + 1,
// sign_f = op, so every operation carries a recognisable result.
module tb_fp_addsub_sched;
    logic clk = 1'b0;
    logic clear;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fp_addsub_sched_if #(.MW(48), .EW(16)) bus ();

    fp_addsub_sched #(.LAT(5), .MW(48), .EW(16)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    logic [47:0] sm [1:5];
    logic [15:0] se [1:5];
    logic        so [1:5];

    // Stand-in datapath stage registers.
    always @(posedge clk) begin
        if (bus.pipe_clear) begin
            for (int k = 1; k <= 5; k++) begin
                sm[k] <= '0;
                se[k] <= '0;
                so[k] <= 1'b0;
            end
        end else if (bus.pipe_load) begin
            sm[1] <= bus.pipe_mant;
            se[1] <= bus.pipe_exp;
            so[1] <= bus.pipe_op;
            for (int k = 2; k <= 5; k++) begin
                sm[k] <= sm[k-1];
                se[k] <= se[k-1];
                so[k] <= so[k-1];
            end
        end
    end

    assign bus.pipe_mant_f = sm[5][23:1];
    assign bus.pipe_exp_f  = se[5][15:8] + 8'd1;
    assign bus.pipe_sign_f = so[5];

    function automatic logic [47:0] dm(input int n, input int k);
        logic [47:0] r;
        r = 48'h800000_000000;
        r[20] = k[0];
        r[19:1] = n[18:0];
        return r;
    endfunction

    function automatic logic [22:0] fm(input int n, input int k);
        logic [22:0] r;
        r = '0;
        r[19] = k[0];
        r[18:0] = n[18:0];
        return r;
    endfunction

    function automatic logic [15:0] de(input int n, input int k);
        logic [15:0] r;
        r = '0;
        r[15:8] = 8'(16 * k + n);
        return r;
    endfunction

    function automatic logic [7:0] fe(input int n, input int k);
        return 8'(16 * k + n + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input int n);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_mant  = dm(n, 0);
        bus.req1_mant  = dm(n, 1);
        bus.req0_exp   = de(n, 0);
        bus.req1_exp   = de(n, 1);
        bus.req0_op    = 1'b0;
        bus.req1_op    = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, 1'b0, 0);
        bus.res_ready = 1'b1;
        tick();
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        bus.res_ready = 1'b1;
        drive(1'b1, 1'b1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready);
            end
            total++;
            if (bus.pipe_clear !== 1'b1 || bus.pipe_load !== 1'b0 || bus.res_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctrl got clr=%b load=%b rv=%b exp clr=1 load=0 rv=0",
                         bus.pipe_clear, bus.pipe_load, bus.res_valid);
            end
            @(posedge clk);
        end
        #1;
        total++;
        if (bus.inflight !== 3'd0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_inflight got=%0d busy=%b exp=0 busy=0", bus.inflight, bus.busy);
        end
        clear = 1'b0;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        total++;
        if (bus.pipe_load !== 1'b1 || bus.pipe_clear !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got load=%b clr=%b exp load=1 clr=0", bus.pipe_load, bus.pipe_clear);
        end
        drive(1'b0, 1'b0, 0);
        tick();
    endtask

    task automatic test_single();
        do_clear();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_mant  = 48'h800000_800000;
        bus.req0_exp   = 16'h7F7F;
        bus.req0_op    = 1'b0;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.pipe_mant !== 48'h800000_800000 ||
            bus.pipe_exp !== 16'h7F7F || bus.pipe_op !== 1'b0) begin
            bad++;
            $display("FAIL single_issue got rdy=%b mant=%h exp=%h op=%b exp rdy=1 mant=800000800000 exp=7f7f op=0",
                     bus.req0_ready, bus.pipe_mant, bus.pipe_exp, bus.pipe_op);
        end
        tick();
        bus.req0_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            total++;
            if (bus.inflight !== ((c <= 5) ? 3'd1 : 3'd0)) begin
                bad++;
                $display("FAIL single_inflight c=%0d got=%0d exp=%0d", c, bus.inflight, (c <= 5) ? 1 : 0);
            end
            total++;
            if (bus.res_valid !== (c == 5)) begin
                bad++;
                $display("FAIL single_res_valid c=%0d got=%b exp=%b", c, bus.res_valid, c == 5);
            end
            if (c == 1) begin
                total++;
                if (bus.pipe_mant !== 48'h0 || bus.pipe_exp !== 16'h0) begin
                    bad++;
                    $display("FAIL single_bubble got mant=%h exp=%h exp 0", bus.pipe_mant, bus.pipe_exp);
                end
            end
            if (c == 5) begin
                total++;
                if (bus.res_tag !== 1'b0 || bus.res_mant !== 23'h400000 ||
                    bus.res_exp !== 8'h80 || bus.res_sign !== 1'b0) begin
                    bad++;
                    $display("FAIL single_result got tag=%b mant=%h exp=%h sign=%b exp tag=0 mant=400000 exp=80 sign=0",
                             bus.res_tag, bus.res_mant, bus.res_exp, bus.res_sign);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_clear();
        for (int c = 0; c <= 13; c++) begin
            drive(c < 8, c < 8, c);
            #1;
            if (c < 8) begin
                total++;
                if (bus.req0_ready !== (c % 2 == 0) || bus.req1_ready !== (c % 2 == 1)) begin
                    bad++;
                    $display("FAIL rr_grant c=%0d got=%b%b exp=%b%b", c, bus.req0_ready, bus.req1_ready,
                             c % 2 == 0, c % 2 == 1);
                end
            end
            total++;
            if (bus.res_valid !== (c >= 5 && c < 13)) begin
                bad++;
                $display("FAIL rr_res_valid c=%0d got=%b exp=%b", c, bus.res_valid, c >= 5 && c < 13);
            end
            if (c >= 5 && c < 13) begin
                total++;
                if (bus.res_tag !== 1'((c - 5) % 2) || bus.res_mant !== fm(c - 5, (c - 5) % 2) ||
                    bus.res_exp !== fe(c - 5, (c - 5) % 2) || bus.res_sign !== 1'((c - 5) % 2)) begin
                    bad++;
                    $display("FAIL rr_result j=%0d got tag=%b mant=%h exp=%h exp tag=%0d mant=%h exp=%h",
                             c - 5, bus.res_tag, bus.res_mant, bus.res_exp, (c - 5) % 2,
                             fm(c - 5, (c - 5) % 2), fe(c - 5, (c - 5) % 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        int n;
        int j;
        logic exp_load;
        n = 0;
        j = 0;
        do_clear();
        for (int c = 0; c <= 24; c++) begin
            exp_load = !(c >= 6 && c <= 8);
            bus.res_ready = exp_load;
            drive(n < 10, n < 10, n);
            #1;
            total++;
            if (bus.pipe_load !== exp_load) begin
                bad++;
                $display("FAIL bp_load c=%0d got=%b exp=%b", c, bus.pipe_load, exp_load);
            end
            if (n < 10) begin
                total++;
                if (bus.req0_ready !== (exp_load && n % 2 == 0) || bus.req1_ready !== (exp_load && n % 2 == 1)) begin
                    bad++;
                    $display("FAIL bp_grant c=%0d got=%b%b exp=%b%b", c, bus.req0_ready, bus.req1_ready,
                             exp_load && n % 2 == 0, exp_load && n % 2 == 1);
                end
            end
            if (!exp_load) begin
                total++;
                if (bus.res_valid !== 1'b1 || bus.inflight !== 3'd5 || bus.res_tag !== 1'b1 ||
                    bus.res_mant !== fm(1, 1)) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d got rv=%b inf=%0d tag=%b mant=%h exp rv=1 inf=5 tag=1 mant=%h",
                             c, bus.res_valid, bus.inflight, bus.res_tag, bus.res_mant, fm(1, 1));
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                total++;
                if (j >= 10 || bus.res_tag !== 1'(j % 2) || bus.res_mant !== fm(j, j % 2)) begin
                    bad++;
                    $display("FAIL bp_order j=%0d got tag=%b mant=%h exp tag=%0d mant=%h",
                             j, bus.res_tag, bus.res_mant, j % 2, fm(j, j % 2));
                end
                j++;
            end
            if (exp_load && n < 10) n++;
            tick();
        end
        total++;
        if (j != 10) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=10", j);
        end
    endtask

    task automatic test_bubbles();
        do_clear();
        for (int c = 0; c <= 15; c++) begin
            drive(c < 10 && c % 2 == 0, 1'b0, c);
            #1;
            total++;
            if (bus.pipe_load !== 1'b1 || bus.req0_ready !== (c < 10 && c % 2 == 0)) begin
                bad++;
                $display("FAIL bub_issue c=%0d got load=%b rdy=%b exp load=1 rdy=%b",
                         c, bus.pipe_load, bus.req0_ready, c < 10 && c % 2 == 0);
            end
            total++;
            if (bus.inflight > 3'd3) begin
                bad++;
                $display("FAIL bub_inflight c=%0d got=%0d exp<=3", c, bus.inflight);
            end
            total++;
            if (bus.res_valid !== (c >= 5 && c < 15 && (c - 5) % 2 == 0)) begin
                bad++;
                $display("FAIL bub_res_valid c=%0d got=%b exp=%b", c, bus.res_valid,
                         c >= 5 && c < 15 && (c - 5) % 2 == 0);
            end
            if (c >= 5 && c < 15 && (c - 5) % 2 == 0) begin
                total++;
                if (bus.res_tag !== 1'b0 || bus.res_mant !== fm(c - 5, 0)) begin
                    bad++;
                    $display("FAIL bub_result c=%0d got tag=%b mant=%h exp tag=0 mant=%h",
                             c, bus.res_tag, bus.res_mant, fm(c - 5, 0));
                end
            end
            tick();
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        for (int c = 0; c <= 17; c++) begin
            clear = (c == 3);
            drive(c <= 3, c == 11, c);
            #1;
            if (c == 2) begin
                total++;
                if (bus.inflight !== 3'd2) begin
                    bad++;
                    $display("FAIL clr_pre_inflight got=%0d exp=2", bus.inflight);
                end
            end
            if (c == 3) begin
                total++;
                if (bus.req0_ready !== 1'b0 || bus.pipe_load !== 1'b0 || bus.pipe_clear !== 1'b1) begin
                    bad++;
                    $display("FAIL clr_during got rdy=%b load=%b clr=%b exp 0 0 1",
                             bus.req0_ready, bus.pipe_load, bus.pipe_clear);
                end
            end
            if (c == 4) begin
                total++;
                if (bus.inflight !== 3'd0 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL clr_after got inf=%0d busy=%b exp 0 0", bus.inflight, bus.busy);
                end
            end
            if (c == 11) begin
                total++;
                if (bus.req1_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL clr_new_issue got=%b exp=1", bus.req1_ready);
                end
            end
            total++;
            if (bus.res_valid !== (c == 16)) begin
                bad++;
                $display("FAIL clr_res_valid c=%0d got=%b exp=%b", c, bus.res_valid, c == 16);
            end
            if (c == 16) begin
                total++;
                if (bus.res_tag !== 1'b1 || bus.res_mant !== fm(11, 1) || bus.res_sign !== 1'b1) begin
                    bad++;
                    $display("FAIL clr_new_result got tag=%b mant=%h sign=%b exp tag=1 mant=%h sign=1",
                             bus.res_tag, bus.res_mant, bus.res_sign, fm(11, 1));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_bubbles();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
